// File: rtl/vexriscv_io_regs.sv
// rtl/vexriscv_io_regs.sv - memory-mapped GPIO, edge event, timer and PWM registers for the dBus IO region
module vexriscv_io_regs #(
  parameter int          WL         = 32,
  parameter int          N_OUT      = 4,
  parameter int          N_IN       = 8,
  parameter int          N_PWM      = 2,
  parameter int          PWM_CNT_WL = 16,
  parameter logic [31:0] ID_VALUE   = 32'h10B0_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_sel,
  input  logic             dBus_cmd_valid,
  input  logic             dBus_cmd_payload_wr,
  input  logic [WL-1:0]    dBus_cmd_payload_address,
  input  logic [WL-1:0]    dBus_cmd_payload_data,
  input  logic [1:0]       dBus_cmd_payload_size,
  output logic             dBus_rsp_ready,
  output logic             dBus_rsp_error,
  output logic [WL-1:0]    dBus_rsp_data,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic [N_PWM-1:0] pwm_out,
  output logic             timer_irq,
  output logic             ext_irq
);

  localparam int LAST_IDX = 8 + N_PWM;

  logic                  acc, wr_acc, rd_acc;
  logic [3:0]            idx;
  logic [3:0]            bmask;
  logic [WL-1:0]         wmask;
  logic                  we_out, we_evt, we_en, we_tmr, we_cmp, we_per;
  logic [N_PWM-1:0]      we_duty;
  logic [N_IN-1:0]       sync1, sync2, sync3, rise, evt_clr;
  logic [N_IN-1:0]       event_r, irq_en;
  logic [31:0]           timer, timer_cmp;
  logic [PWM_CNT_WL-1:0] period, pwm_cnt;
  logic [PWM_CNT_WL-1:0] shadow [N_PWM];
  logic [PWM_CNT_WL-1:0] active [N_PWM];
  logic [PWM_CNT_WL-1:0] duty_nxt [N_PWM];
  logic                  wrap;
  logic [WL-1:0]         rdata;
  logic                  rerr;
  logic                  unused_addr;

  function automatic logic [WL-1:0] merge(input logic [WL-1:0] old_v,
                                          input logic [WL-1:0] new_v,
                                          input logic [WL-1:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign acc    = dBus_cmd_valid && io_sel;
  assign wr_acc = acc && dBus_cmd_payload_wr;
  assign rd_acc = acc && !dBus_cmd_payload_wr;
  assign idx    = dBus_cmd_payload_address[5:2];
  assign unused_addr = ^dBus_cmd_payload_address[WL-1:6];

  always_comb begin
    case (dBus_cmd_payload_size)
      2'd0:    bmask = 4'b0001 << dBus_cmd_payload_address[1:0];
      2'd1:    bmask = 4'b0011 << dBus_cmd_payload_address[1:0];
      default: bmask = 4'b1111;
    endcase
    wmask = '0;
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{bmask[b]}};
  end

  always_comb begin
    we_out = wr_acc && (idx == 4'd1);
    we_evt = wr_acc && (idx == 4'd3);
    we_en  = wr_acc && (idx == 4'd4);
    we_tmr = wr_acc && (idx == 4'd5);
    we_cmp = wr_acc && (idx == 4'd6);
    we_per = wr_acc && (idx == 4'd8);
    for (int k = 0; k < N_PWM; k++) begin
      we_duty[k]  = wr_acc && (idx == 4'(9 + k));
      duty_nxt[k] = we_duty[k]
                  ? PWM_CNT_WL'(merge(WL'(shadow[k]), dBus_cmd_payload_data, wmask))
                  : shadow[k];
    end
  end

  // Two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise    = sync2 & ~sync3;
  assign evt_clr = we_evt ? N_IN'(dBus_cmd_payload_data & wmask) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out  <= '0;
      event_r   <= '0;
      irq_en    <= '0;
      timer     <= '0;
      timer_cmp <= 32'hFFFF_FFFF;
      timer_irq <= 1'b0;
      ext_irq   <= 1'b0;
    end else begin
      if (we_out) gpio_out <= N_OUT'(merge(WL'(gpio_out), dBus_cmd_payload_data, wmask));
      if (we_en)  irq_en   <= N_IN'(merge(WL'(irq_en), dBus_cmd_payload_data, wmask));
      // a new edge wins over a simultaneous clear of the same bit
      event_r <= (event_r & ~evt_clr) | rise;
      if (we_tmr) timer <= 32'(merge(WL'(timer), dBus_cmd_payload_data, wmask));
      else        timer <= timer + 32'd1;
      if (we_cmp) timer_cmp <= 32'(merge(WL'(timer_cmp), dBus_cmd_payload_data, wmask));
      timer_irq <= (timer >= timer_cmp);
      ext_irq   <= |(event_r & irq_en);
    end
  end

  // With PERIOD = 0 the counter wraps every cycle, so duty writes take effect at once
  assign wrap = (pwm_cnt >= period);

  always_ff @(posedge clk) begin
    if (reset) begin
      period  <= '0;
      pwm_cnt <= '0;
      for (int k = 0; k < N_PWM; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (we_per) period <= PWM_CNT_WL'(merge(WL'(period), dBus_cmd_payload_data, wmask));
      for (int k = 0; k < N_PWM; k++) begin
        if (we_duty[k]) shadow[k] <= duty_nxt[k];
      end
      if (we_per || wrap) begin
        pwm_cnt <= '0;
        for (int k = 0; k < N_PWM; k++) active[k] <= duty_nxt[k];
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pwm_out = '0;
    for (int k = 0; k < N_PWM; k++) pwm_out[k] = (pwm_cnt < active[k]);
  end

  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    case (idx)
      4'd0: rdata = WL'(ID_VALUE);
      4'd1: rdata[N_OUT-1:0] = gpio_out;
      4'd2: rdata[N_IN-1:0] = sync2;
      4'd3: rdata[N_IN-1:0] = event_r;
      4'd4: rdata[N_IN-1:0] = irq_en;
      4'd5: rdata[31:0] = timer;
      4'd6: rdata[31:0] = timer_cmp;
      4'd7: rdata[1:0] = {ext_irq, timer_irq};
      4'd8: rdata[PWM_CNT_WL-1:0] = period;
      default: begin
        rerr = (idx > 4'(LAST_IDX));
        for (int k = 0; k < N_PWM; k++) begin
          if (idx == 4'(9 + k)) rdata[PWM_CNT_WL-1:0] = shadow[k];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dBus_rsp_ready <= 1'b0;
      dBus_rsp_error <= 1'b0;
      dBus_rsp_data  <= '0;
    end else begin
      dBus_rsp_ready <= rd_acc;
      dBus_rsp_error <= rd_acc && rerr;
      dBus_rsp_data  <= rd_acc ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_vexriscv_io_regs.sv
// tb/tb_vexriscv_io_regs.sv - self-checking bench for vexriscv_io_regs
module tb_vexriscv_io_regs;

  localparam logic [31:0] ID = 32'h10B0_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_sel, valid, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [7:0]  gpio_in;
  logic        dBus_rsp_ready, dBus_rsp_error;
  logic [31:0] dBus_rsp_data;
  logic [3:0]  gpio_out;
  logic [1:0]  pwm_out;
  logic        timer_irq, ext_irq;

  int tests  = 0;
  int failed = 0;

  vexriscv_io_regs dut (
    .clk                      (clk),
    .reset                    (reset),
    .io_sel                   (io_sel),
    .dBus_cmd_valid           (valid),
    .dBus_cmd_payload_wr      (wr),
    .dBus_cmd_payload_address (addr),
    .dBus_cmd_payload_data    (wdata),
    .dBus_cmd_payload_size    (size),
    .dBus_rsp_ready           (dBus_rsp_ready),
    .dBus_rsp_error           (dBus_rsp_error),
    .dBus_rsp_data            (dBus_rsp_data),
    .gpio_in                  (gpio_in),
    .gpio_out                 (gpio_out),
    .pwm_out                  (pwm_out),
    .timer_irq                (timer_irq),
    .ext_irq                  (ext_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; io_sel = 1'b0; wr = 1'b0;
  endtask

  task automatic drive(input bit w, input int ix, input int off, input int sz, input logic [31:0] d);
    valid = 1'b1; io_sel = 1'b1; wr = w;
    addr  = 32'h8000_0000 | 32'(ix << 2) | 32'(off);
    size  = 2'(sz);
    wdata = d;
  endtask

  task automatic bus_write(input int ix, input logic [31:0] d, input int sz = 2, input int off = 0);
    drive(1'b1, ix, off, sz, d);
    tick();
    idle();
  endtask

  task automatic bus_read(input int ix, output logic [31:0] d, output logic e, output logic r);
    drive(1'b0, ix, 0, 2, 32'h0);
    tick();
    r = dBus_rsp_ready; d = dBus_rsp_data; e = dBus_rsp_error;
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, r;
    reset = 1'b1; idle(); gpio_in = '0; addr = '0; wdata = '0; size = '0;
    repeat (3) tick();
    tests++; if ({gpio_out, pwm_out, timer_irq, ext_irq, dBus_rsp_ready, dBus_rsp_error} !== 10'b0) begin failed++; $display("FAIL reset_outputs: got %b want 0", {gpio_out, pwm_out, timer_irq, ext_irq, dBus_rsp_ready, dBus_rsp_error}); end
    tests++; if (dBus_rsp_data !== 32'h0) begin failed++; $display("FAIL reset_rsp_data: got %h want 0", dBus_rsp_data); end
    reset = 1'b0;
    bus_read(0, d, e, r);
    tests++; if ({r, e, d} !== {1'b1, 1'b0, ID}) begin failed++; $display("FAIL read_id: got rdy=%b err=%b data=%h want 1 0 %h", r, e, d, ID); end
    tick();
    tests++; if (dBus_rsp_ready !== 1'b0) begin failed++; $display("FAIL rsp_pulse_width: got %b want 0", dBus_rsp_ready); end
    bus_read(15, d, e, r);
    tests++; if ({r, e, d} !== {1'b1, 1'b1, 32'h0}) begin failed++; $display("FAIL read_unmapped: got rdy=%b err=%b data=%h want 1 1 0", r, e, d); end
    bus_read(6, d, e, r);
    tests++; if (d !== 32'hFFFF_FFFF) begin failed++; $display("FAIL read_cmp_reset: got %h want ffffffff", d); end
  endtask

  task automatic test_gpio_out();
    logic [31:0] d; logic e, r;
    bus_write(1, 32'hA5A5_A5A5, 0, 1);
    tests++; if (gpio_out !== 4'h0) begin failed++; $display("FAIL out_byte_lane1: got %h want 0", gpio_out); end
    bus_write(1, 32'h0000_000F);
    tests++; if (gpio_out !== 4'hF) begin failed++; $display("FAIL out_word: got %h want f", gpio_out); end
    bus_write(1, 32'h0000_0000, 1, 2);
    tests++; if (gpio_out !== 4'hF) begin failed++; $display("FAIL out_half_upper: got %h want f", gpio_out); end
    bus_write(1, 32'h0505_0505, 0, 0);
    bus_read(1, d, e, r);
    tests++; if (d !== 32'h5) begin failed++; $display("FAIL out_byte_lane0: got %h want 5", d); end
  endtask

  task automatic test_events();
    logic [31:0] d; logic e, r;
    bus_write(4, 32'h4);
    gpio_in = 8'h04;
    repeat (3) tick();
    tests++; if (ext_irq !== 1'b0) begin failed++; $display("FAIL ext_irq_early: got %b want 0", ext_irq); end
    tick();
    tests++; if (ext_irq !== 1'b1) begin failed++; $display("FAIL ext_irq_latency: got %b want 1", ext_irq); end
    gpio_in = 8'h24;
    tick(); tick();
    bus_read(3, d, e, r);
    tests++; if (d !== 32'h04) begin failed++; $display("FAIL event_latency_before: got %h want 04", d); end
    bus_read(3, d, e, r);
    tests++; if (d !== 32'h24) begin failed++; $display("FAIL event_latency_after: got %h want 24", d); end
    gpio_in = 8'h20;
    repeat (4) tick();
    gpio_in = 8'h24;
    tick(); tick();
    bus_write(3, 32'h4);
    bus_read(3, d, e, r);
    tests++; if (d !== 32'h24) begin failed++; $display("FAIL event_set_wins: got %h want 24", d); end
    bus_write(3, 32'h2020_2020, 0, 1);
    bus_read(3, d, e, r);
    tests++; if (d !== 32'h24) begin failed++; $display("FAIL event_w1c_masked: got %h want 24", d); end
    bus_write(3, 32'h4);
    tick();
    tests++; if (ext_irq !== 1'b0) begin failed++; $display("FAIL ext_irq_clear: got %b want 0", ext_irq); end
    bus_read(3, d, e, r);
    tests++; if (d !== 32'h20) begin failed++; $display("FAIL event_w1c: got %h want 20", d); end
    bus_read(2, d, e, r);
    tests++; if (d !== 32'h24) begin failed++; $display("FAIL in_read: got %h want 24", d); end
    bus_write(3, 32'hFFFF_FFFF);
    bus_read(3, d, e, r);
    tests++; if (d !== 32'h0) begin failed++; $display("FAIL event_clear_all: got %h want 0", d); end
  endtask

  task automatic test_timer();
    logic [31:0] d; logic e, r;
    int n;
    bus_write(5, 32'd100);
    bus_write(6, 32'd110);
    n = 0;
    while (timer_irq !== 1'b1 && n < 100) begin tick(); n++; end
    tests++; if (n != 10) begin failed++; $display("FAIL timer_irq_latency: got %0d cycles want 10", n); end
    bus_write(6, 32'hFFFF_FFFF);
    tick();
    tests++; if (timer_irq !== 1'b0) begin failed++; $display("FAIL timer_irq_clear: got %b want 0", timer_irq); end
    bus_write(5, 32'hFFFF_FFFE);
    bus_read(5, d, e, r);
    tests++; if (d !== 32'hFFFF_FFFE) begin failed++; $display("FAIL timer_write_wins: got %h want fffffffe", d); end
    bus_read(5, d, e, r);
    tests++; if (d !== 32'hFFFF_FFFF) begin failed++; $display("FAIL timer_incr: got %h want ffffffff", d); end
    bus_read(5, d, e, r);
    tests++; if (d !== 32'h0) begin failed++; $display("FAIL timer_wrap: got %h want 0", d); end
  endtask

  task automatic test_pwm();
    int  bad;
    bit  exp0;
    bus_write(9, 32'd3);
    tests++; if (pwm_out !== 2'b01) begin failed++; $display("FAIL pwm_period0_immediate: got %b want 01", pwm_out); end
    bus_write(8, 32'd9);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      exp0 = (i < 30) ? ((i % 10) < 3) : 1'b1;
      if (pwm_out !== {1'b0, exp0}) bad++;
      if (i == 24) drive(1'b1, 9, 0, 2, 32'd12);
      tick();
      idle();
    end
    tests++; if (bad != 0) begin failed++; $display("FAIL pwm_pattern: got %0d bad samples want 0", bad); end
    bus_write(9, 32'd0);
    repeat (12) tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out !== 2'b00) bad++;
      tick();
    end
    tests++; if (bad != 0) begin failed++; $display("FAIL pwm_duty0: got %0d bad samples want 0", bad); end
    bus_write(8, 32'd0);
    bus_write(10, 32'd5);
    tests++; if (pwm_out !== 2'b10) begin failed++; $display("FAIL pwm_period0_duty1: got %b want 10", pwm_out); end
    bus_write(10, 32'd0);
    tests++; if (pwm_out !== 2'b00) begin failed++; $display("FAIL pwm_period0_off: got %b want 00", pwm_out); end
  endtask

  task automatic test_random_regs();
    logic [31:0] st [16];
    logic [31:0] wid [16];
    int          idxs [13] = '{0, 1, 2, 4, 6, 8, 9, 10, 11, 12, 13, 14, 15};
    bit          go, sel, w, is_rd;
    int          ix, sz, off;
    logic [31:0] d, m32, exp_d;
    logic [3:0]  bm;
    logic        exp_e;
    for (int i = 0; i < 16; i++) begin st[i] = '0; wid[i] = '0; end
    wid[1] = 32'hF; wid[4] = 32'hFF; wid[6] = 32'hFFFF_FFFF;
    wid[8] = 32'hFFFF; wid[9] = 32'hFFFF; wid[10] = 32'hFFFF;
    st[0] = ID; st[2] = {24'h0, gpio_in};
    foreach (wid[i]) if (wid[i] != 0) begin
      st[i] = $urandom() & wid[i];
      bus_write(i, st[i]);
    end
    for (int c = 0; c < 400; c++) begin
      go  = ($urandom_range(0, 9) != 0);
      sel = ($urandom_range(0, 7) != 0);
      w   = 1'($urandom_range(0, 1));
      ix  = idxs[$urandom_range(0, 12)];
      sz  = $urandom_range(0, 2);
      off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      d   = $urandom();
      if (go) begin drive(w, ix, off, sz, d); io_sel = sel; end else idle();
      is_rd = go && sel && !w;
      exp_d = (ix <= 10) ? st[ix] : 32'h0;
      exp_e = (ix > 10);
      tick();
      tests++; if (dBus_rsp_ready !== is_rd) begin failed++; $display("FAIL rand_rsp_ready c=%0d: got %b want %b", c, dBus_rsp_ready, is_rd); end
      if (is_rd) begin
        tests++; if ({dBus_rsp_error, dBus_rsp_data} !== {exp_e, exp_d}) begin failed++; $display("FAIL rand_read idx=%0d: got err=%b data=%h want err=%b data=%h", ix, dBus_rsp_error, dBus_rsp_data, exp_e, exp_d); end
      end
      if (go && sel && w && wid[ix] != 0) begin
        bm  = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
        m32 = '0;
        for (int b = 0; b < 4; b++) if (bm[b]) m32[8*b +: 8] = 8'hFF;
        st[ix] = ((st[ix] & ~m32) | (d & m32)) & wid[ix];
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e, r;
    bus_write(8, 32'd9);
    bus_write(9, 32'd5);
    bus_write(1, 32'hF);
    bus_write(6, 32'd0);
    bus_write(4, 32'hFF);
    gpio_in = 8'h25;
    repeat (5) tick();
    tests++; if ({gpio_out, timer_irq, ext_irq} !== 6'b111111) begin failed++; $display("FAIL pre_reset_state: got %b want 111111", {gpio_out, timer_irq, ext_irq}); end
    gpio_in = 8'h00;
    drive(1'b0, 6, 0, 2, 32'h0);
    reset = 1'b1;
    tick();
    idle();
    tests++; if ({gpio_out, pwm_out, timer_irq, ext_irq, dBus_rsp_ready, dBus_rsp_error} !== 10'b0) begin failed++; $display("FAIL mid_reset_outputs: got %b want 0", {gpio_out, pwm_out, timer_irq, ext_irq, dBus_rsp_ready, dBus_rsp_error}); end
    reset = 1'b0;
    tick();
    tests++; if (dBus_rsp_ready !== 1'b0) begin failed++; $display("FAIL mid_reset_no_rsp: got %b want 0", dBus_rsp_ready); end
    bus_read(6, d, e, r);
    tests++; if (d !== 32'hFFFF_FFFF) begin failed++; $display("FAIL mid_reset_cmp: got %h want ffffffff", d); end
    bus_read(8, d, e, r);
    tests++; if (d !== 32'h0) begin failed++; $display("FAIL mid_reset_period: got %h want 0", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_gpio_out();
    test_events();
    test_timer();
    test_pwm();
    test_random_regs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
